// File: rtl/maxpool_stage.sv
// -----------------------------------------------------------------------------
// maxpool_stage
//   2x2 / stride-2 signed max-pooling over a raster-ordered feature map.
//   Even input rows fold each horizontal pixel pair into a row buffer.
//   Odd rows fold their pair with the buffered value and emit one pooled
//   sample, one cycle after the accepting edge.
//
// Configuration macro:
//   MAXPOOL_RELU_EN - when defined, negative input pixels are replaced
//                     by 0 before pooling.
//
// Ports:
//   clock       in   single clock, rising edge
//   reset       in   synchronous active-low reset
//   start       in   frame-start strobe (clears input counters and pair reg)
//   pixel_in    in   signed pixel, DATA_WIDTH
//   pixel_rdy   in   pixel_in valid this cycle (no backpressure)
//   pool_out    out  signed 2x2 maximum, DATA_WIDTH
//   pool_valid  out  pool_out / pool_x / pool_y valid this cycle
//   pool_x      out  pooled column, COORD_BITS-1
//   pool_y      out  pooled row, COORD_BITS-1
//   frame_done  out  pulse with the last pool_valid of a frame
// -----------------------------------------------------------------------------
module maxpool_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int IN_WIDTH   = 24,
    parameter int IN_HEIGHT  = 24,
    parameter int COORD_BITS = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] pixel_in,
    input  logic                         pixel_rdy,
    output logic signed [DATA_WIDTH-1:0] pool_out,
    output logic                         pool_valid,
    output logic [COORD_BITS-2:0]        pool_x,
    output logic [COORD_BITS-2:0]        pool_y,
    output logic                         frame_done
);

    localparam int BUF_DEPTH = IN_WIDTH / 2;
    localparam logic [COORD_BITS-1:0] X_LAST = COORD_BITS'(IN_WIDTH - 1);
    localparam logic [COORD_BITS-1:0] Y_LAST = COORD_BITS'(IN_HEIGHT - 1);

    logic [COORD_BITS-1:0]        in_x_q, in_x_d;
    logic [COORD_BITS-1:0]        in_y_q, in_y_d;
    logic signed [DATA_WIDTH-1:0] pair_q, pair_d;
    logic signed [DATA_WIDTH-1:0] pool_out_q, pool_out_d;
    logic [COORD_BITS-2:0]        pool_x_q, pool_x_d;
    logic [COORD_BITS-2:0]        pool_y_q, pool_y_d;
    logic                         pool_valid_q, pool_valid_d;
    logic                         frame_done_q, frame_done_d;

    logic signed [DATA_WIDTH-1:0] row_buf_q [BUF_DEPTH];
    logic                         row_wr_en;

    logic [COORD_BITS-1:0]        cur_x, cur_y;
    logic [COORD_BITS-2:0]        half_x, half_y;
    logic signed [DATA_WIDTH-1:0] pix_eff;
    logic signed [DATA_WIDTH-1:0] pair_max;
    logic signed [DATA_WIDTH-1:0] row_rd;
    logic signed [DATA_WIDTH-1:0] win_max;

    always_comb begin
        // start forces the current pixel (if any) to be coordinate (0,0)
        cur_x  = start ? '0 : in_x_q;
        cur_y  = start ? '0 : in_y_q;
        half_x = cur_x[COORD_BITS-1:1];
        half_y = cur_y[COORD_BITS-1:1];

`ifdef MAXPOOL_RELU_EN
        pix_eff = pixel_in[DATA_WIDTH-1] ? '0 : pixel_in;
`else
        pix_eff = pixel_in;
`endif

        pair_max = (pix_eff > pair_q) ? pix_eff : pair_q;
        row_rd   = row_buf_q[half_x];
        win_max  = (pair_max > row_rd) ? pair_max : row_rd;

        in_x_d       = cur_x;
        in_y_d       = cur_y;
        pair_d       = start ? '0 : pair_q;
        row_wr_en    = 1'b0;
        pool_out_d   = pool_out_q;
        pool_x_d     = pool_x_q;
        pool_y_d     = pool_y_q;
        pool_valid_d = 1'b0;
        frame_done_d = 1'b0;

        if (pixel_rdy) begin
            if (cur_x == X_LAST) begin
                in_x_d = '0;
                in_y_d = (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
            end else begin
                in_x_d = cur_x + 1'b1;
            end

            if (!cur_x[0]) begin
                pair_d = pix_eff;
            end else if (!cur_y[0]) begin
                row_wr_en = 1'b1;
            end else begin
                pool_valid_d = 1'b1;
                pool_out_d   = win_max;
                pool_x_d     = half_x;
                pool_y_d     = half_y;
                frame_done_d = (cur_x == X_LAST) && (cur_y == Y_LAST);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            in_x_q       <= '0;
            in_y_q       <= '0;
            pair_q       <= '0;
            pool_out_q   <= '0;
            pool_x_q     <= '0;
            pool_y_q     <= '0;
            pool_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            in_x_q       <= in_x_d;
            in_y_q       <= in_y_d;
            pair_q       <= pair_d;
            pool_out_q   <= pool_out_d;
            pool_x_q     <= pool_x_d;
            pool_y_q     <= pool_y_d;
            pool_valid_q <= pool_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Row buffer is always rewritten on an even row before it is read,
    // so it carries no reset. Writes are blocked while reset is asserted.
    always_ff @(posedge clock) begin
        if (reset && row_wr_en) begin
            row_buf_q[half_x] <= pair_max;
        end
    end

    assign pool_out   = pool_out_q;
    assign pool_x     = pool_x_q;
    assign pool_y     = pool_y_q;
    assign pool_valid = pool_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool_stage.sv
// -----------------------------------------------------------------------------
// tb_maxpool_stage
//   Scoreboard bench for maxpool_stage (default parameters, 24x24, 16-bit).
//   Stimulus pushes the expected pooled sample when it issues an (odd,odd)
//   pixel; an independent monitor pops and compares on every pool_valid.
// -----------------------------------------------------------------------------
module tb_maxpool_stage;

    localparam int W = 24;
    localparam int H = 24;

    logic               clock = 1'b0;
    logic               reset;
    logic               start;
    logic signed [15:0] pixel_in;
    logic               pixel_rdy;
    logic signed [15:0] pool_out;
    logic               pool_valid;
    logic [3:0]         pool_x;
    logic [3:0]         pool_y;
    logic               frame_done;

    maxpool_stage #(
        .DATA_WIDTH (16),
        .IN_WIDTH   (W),
        .IN_HEIGHT  (H),
        .COORD_BITS (5)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .pixel_in   (pixel_in),
        .pixel_rdy  (pixel_rdy),
        .pool_out   (pool_out),
        .pool_valid (pool_valid),
        .pool_x     (pool_x),
        .pool_y     (pool_y),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int out;
        int x;
        int y;
        int fd;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   nvec     = 0;
    int   nfail    = 0;
    int   cyc      = 0;
    int   pops     = 0;
    int   fd_cnt   = 0;
    bit   mon_en   = 1'b0;
    int   last_out = 0;
    int   last_x   = 0;
    int   last_y   = 0;
    int   mode_g   = 0;
    int   bx       = 0;
    int   by       = 0;

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input int act, input int exp_v);
        nvec++;
        if (act !== exp_v) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic int pix_val(input int mode, input int x, input int y);
        case (mode)
            0:       return 100 * y + x;
            1:       return (x == 0 && y == 0) ? -3 : -5;
            2:       return 7;
            default: return 0;
        endcase
    endfunction

    function automatic int eff(input int v);
`ifdef MAXPOOL_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic int max4(input int x, input int y);
        int m;
        m = eff(pix_val(mode_g, x - 1, y - 1));
        if (eff(pix_val(mode_g, x, y - 1)) > m) m = eff(pix_val(mode_g, x, y - 1));
        if (eff(pix_val(mode_g, x - 1, y)) > m) m = eff(pix_val(mode_g, x - 1, y));
        if (eff(pix_val(mode_g, x, y)) > m)     m = eff(pix_val(mode_g, x, y));
        return m;
    endfunction

    // Monitor: pops on pool_valid, otherwise checks held outputs.
    always @(negedge clock) begin
        if (mon_en) begin
            if (pool_valid) begin
                if (q.size() == 0) begin
                    nvec++;
                    nfail++;
                    $display("FAIL unexpected_valid: got pool_valid=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    pops++;
                    chk("pool_out", int'(pool_out), e.out);
                    chk("pool_x", int'(pool_x), e.x);
                    chk("pool_y", int'(pool_y), e.y);
                    chk("frame_done", int'(frame_done), e.fd);
                    chk("latency", cyc, e.cyc);
                    last_out = e.out;
                    last_x   = e.x;
                    last_y   = e.y;
                end
                if (frame_done) fd_cnt++;
            end else begin
                chk("hold_out", int'(pool_out), last_out);
                chk("hold_x", int'(pool_x), last_x);
                chk("hold_y", int'(pool_y), last_y);
                chk("fd_idle", int'(frame_done), 0);
            end
        end
    end

    task automatic send_pixel(input bit st, input bit gap);
        if (gap) begin
            start     = 1'b0;
            pixel_rdy = 1'b0;
            pixel_in  = 16'sh7fff;
            @(posedge clock);
            #1;
        end
        if (st) begin
            bx = 0;
            by = 0;
        end
        start     = st;
        pixel_rdy = 1'b1;
        pixel_in  = 16'(pix_val(mode_g, bx, by));
        if ((bx % 2 == 1) && (by % 2 == 1)) begin
            exp_t e;
            e.out = max4(bx, by);
            e.x   = bx / 2;
            e.y   = by / 2;
            e.fd  = (bx == W - 1 && by == H - 1) ? 1 : 0;
            e.cyc = cyc + 1;
            q.push_back(e);
        end
        @(posedge clock);
        #1;
        start     = 1'b0;
        pixel_rdy = 1'b0;
        pixel_in  = 16'sh5a5a;
        if (bx == W - 1) begin
            bx = 0;
            by = (by == H - 1) ? 0 : by + 1;
        end else begin
            bx++;
        end
    endtask

    task automatic run_pixels(input int n, input bit gap);
        for (int i = 0; i < n; i++) send_pixel(1'b0, gap);
    endtask

    task automatic start_only();
        start     = 1'b1;
        pixel_rdy = 1'b0;
        @(posedge clock);
        #1;
        start = 1'b0;
        bx    = 0;
        by    = 0;
    endtask

    task automatic drain(input string name);
        repeat (3) @(posedge clock);
        #1;
        chk(name, q.size(), 0);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_valid"}, int'(pool_valid), 0);
        chk({name, "_fd"}, int'(frame_done), 0);
        chk({name, "_out"}, int'(pool_out), 0);
        chk({name, "_x"}, int'(pool_x), 0);
        chk({name, "_y"}, int'(pool_y), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int f0;
        reset     = 1'b0;
        start     = 1'b0;
        pixel_rdy = 1'b0;
        pixel_in  = '0;
        repeat (2) @(posedge clock);
        #1;
        check_zero("reset");
        reset  = 1'b1;
        mon_en = 1'b1;

        // Ramp frame, continuous
        mode_g = 0;
        start_only();
        p0 = pops; f0 = fd_cnt;
        run_pixels(W * H, 1'b0);
        drain("ramp_drain");
        chk("ramp_pulses", pops - p0, 144);
        chk("ramp_fd", fd_cnt - f0, 1);

        // Ramp frame, gapped
        start_only();
        p0 = pops; f0 = fd_cnt;
        run_pixels(W * H, 1'b1);
        drain("gap_drain");
        chk("gap_pulses", pops - p0, 144);
        chk("gap_fd", fd_cnt - f0, 1);

        // Negative frame
        mode_g = 1;
        start_only();
        p0 = pops; f0 = fd_cnt;
        run_pixels(W * H, 1'b0);
        drain("neg_drain");
        chk("neg_pulses", pops - p0, 144);
        chk("neg_fd", fd_cnt - f0, 1);

        // Start mid-frame, start coincident with first pixel
        mode_g = 0;
        start_only();
        run_pixels(100, 1'b0);
        p0 = pops; f0 = fd_cnt;
        send_pixel(1'b1, 1'b0);
        run_pixels(W * H - 1, 1'b0);
        drain("mid_start_drain");
        chk("mid_start_pulses", pops - p0, 144);
        chk("mid_start_fd", fd_cnt - f0, 1);

        // Reset mid-frame, with a pixel offered during reset
        start_only();
        run_pixels(300, 1'b0);
        reset     = 1'b0;
        pixel_rdy = 1'b1;
        pixel_in  = 16'sd1234;
        @(posedge clock);
        #1;
        reset     = 1'b1;
        pixel_rdy = 1'b0;
        last_out  = 0;
        last_x    = 0;
        last_y    = 0;
        check_zero("mid_reset");
        bx = 0;
        by = 0;
        p0 = pops; f0 = fd_cnt;
        run_pixels(W * H, 1'b0);
        drain("mid_reset_drain");
        chk("mid_reset_pulses", pops - p0, 144);
        chk("mid_reset_fd", fd_cnt - f0, 1);

        // Constant 7, two frames back to back with no second start
        mode_g = 2;
        start_only();
        p0 = pops; f0 = fd_cnt;
        run_pixels(2 * W * H, 1'b0);
        drain("tie_drain");
        chk("tie_pulses", pops - p0, 288);
        chk("tie_fd", fd_cnt - f0, 2);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/maxpool_stage.md
MAXPOOL_STAGE -- requirements
Module: maxpool_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of the signed two's-complement pixel.
REQ-002 Parameter IN_WIDTH, default 24: input feature-map columns; SHALL be even.
REQ-003 Parameter IN_HEIGHT, default 24: input feature-map rows; SHALL be even.
REQ-004 Parameter COORD_BITS, default 5: width of the internal input counters; pool_x and pool_y are COORD_BITS-1 wide.
REQ-005 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-low reset, sampled on the rising edge of clock.
REQ-007 Port start, input, 1: single-cycle strobe that marks the beginning of a new frame.
REQ-008 Port pixel_in, input, DATA_WIDTH: signed convolution result from the multiply-adder pipeline.
REQ-009 Port pixel_rdy, input, 1: pixel_in is valid this cycle. It may be continuous or gapped, in raster order, and has no backpressure.
REQ-010 Port pool_out, output, DATA_WIDTH: signed 2x2 maximum.
REQ-011 Port pool_valid, output, 1: pool_out, pool_x and pool_y are valid this cycle.
REQ-012 Port pool_x / pool_y, output, COORD_BITS-1 each: pooled-map column and row of pool_out.
REQ-013 Port frame_done, output, 1: single-cycle pulse coincident with the last pool_valid of a frame.

Function
REQ-014 The block SHALL keep input counters in_x and in_y, and SHALL advance them only on pixel_rdy.
- in_x increments up to IN_WIDTH-1, then wraps to 0 and increments in_y.
- in_y wraps from IN_HEIGHT-1 to 0.
REQ-015 When pixel_rdy is high and in_x is even, the block SHALL capture pixel_in into a pair register.
REQ-016 When pixel_rdy is high and in_x is odd, the block SHALL form pair_max = signed max(pair register, pixel_in).
REQ-017 When in_y is even, the block SHALL write pair_max into row buffer entry in_x>>1. The row buffer is IN_WIDTH/2 entries of DATA_WIDTH bits.
REQ-018 When in_y is odd, the block SHALL register the following, with pool_valid=1 in the cycle after the accepting edge (latency 1 cycle):
- pool_out = signed max(row buffer[in_x>>1], pair_max)
- pool_x = in_x>>1
- pool_y = in_y>>1
REQ-019 pool_valid SHALL be high for exactly one cycle per 2x2 window. A frame produces (IN_WIDTH/2)*(IN_HEIGHT/2) pulses.
REQ-020 On a tie, pool_out SHALL equal the common value. Comparisons SHALL be signed, and no widening or saturation is applied.
REQ-021 frame_done SHALL assert together with pool_valid when pool_x=IN_WIDTH/2-1 and pool_y=IN_HEIGHT/2-1.
REQ-022 When start is high, in_x, in_y and the pair register SHALL clear to 0.
- If pixel_rdy is high in the same cycle, that pixel is accepted as coordinate (0,0).
- A start pulse mid-frame abandons the partial frame with no further pool_valid for it.
REQ-023 pool_out, pool_x and pool_y SHALL hold their last values while pool_valid is 0.
REQ-024 Row buffer contents SHALL NOT be cleared by start. Each entry is rewritten on an even row before it is read.

Reset
REQ-025 With reset low at a rising edge, the block SHALL clear in_x, in_y, the pair register, pool_out, pool_x, pool_y, pool_valid and frame_done to 0.
REQ-026 Reset SHALL take priority over start and pixel_rdy. Reset mid-frame discards the partial frame, and the next accepted pixel is (0,0).
REQ-027 The row buffer SHALL need no reset.

Configuration
REQ-028 With the macro MAXPOOL_RELU_EN defined, the block SHALL replace pixel_in with 0 before pooling when pixel_in is negative, so pool_out is never negative.
REQ-029 Without MAXPOOL_RELU_EN, the block SHALL pool raw signed values, and negative maxima SHALL pass through unchanged.

Verification
REQ-030 Ramp test:
- Stimulus: reset, start, then 576 consecutive pixels with value 100*y+x (24x24).
- Required: first pool_valid one cycle after pixel (1,1) with pool_out=101, pool_x=0, pool_y=0.
- Required: 144 pool_valid pulses total, the last with pool_out=2323 at (11,11) together with frame_done=1.
REQ-031 Gapped test:
- Stimulus: the same frame with pixel_rdy low on every other cycle.
- Required: identical pool_out, pool_x, pool_y sequence as REQ-030, each pulse 1 cycle after its (odd,odd) pixel.
REQ-032 Negative test:
- Stimulus: all pixels -5 except pixel (0,0)=-3.
- Required without MAXPOOL_RELU_EN: window (0,0) gives -3 and all other windows give -5.
- Required with MAXPOOL_RELU_EN: all 144 outputs are 0.
REQ-033 Start mid-frame:
- Stimulus: start after 100 pixels, with pixel_rdy high in the same cycle, then 576 more pixels.
- Required: the next pool_valid follows the 26th post-start pixel, at (0,0).
- Required: exactly 144 further pulses, frame_done on the last.
REQ-034 Reset mid-frame:
- Stimulus: reset low for 1 cycle at pixel 300.
- Required: all outputs 0 the following cycle, and the next frame starts pooling at (0,0).
REQ-035 Tie and wrap:
- Stimulus: constant value 7 for 2 back-to-back frames.
- Required: 288 pulses, all pool_out=7.
- Required: frame_done pulses exactly twice, and the second frame's coordinates restart at (0,0) without a start pulse.
